// File: rtl/vend_pkg.sv
// Purpose: shared types and default sizes for the vending transaction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vend_pkg;

    localparam int VEND_ITEM_ADDR_WIDTH = 10;
    localparam int VEND_COIN_WIDTH      = 8;
    localparam int VEND_CREDIT_WIDTH    = 12;
    localparam int VEND_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRICE_RD  = 3'd1,
        ST_PRICE_CHK = 3'd2,
        ST_COLLECT   = 3'd3,
        ST_DISPENSE  = 3'd4,
        ST_CHANGE    = 3'd5
    } vend_state_t;

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Purpose: bundles selection, price RAM, coin, dispense and change signals of vend_txn_ctrl.
// Latency: n/a (wiring only).
// Backpressure: dispense and change use valid/ready; master = controller side, slave = environment.
interface vend_txn_ctrl_if
    import vend_pkg::*;
#(
    parameter int ITEM_ADDR_WIDTH = VEND_ITEM_ADDR_WIDTH,
    parameter int COIN_WIDTH      = VEND_COIN_WIDTH,
    parameter int CREDIT_WIDTH    = VEND_CREDIT_WIDTH
);
    // selection from item_select
    logic [ITEM_ADDR_WIDTH-1:0] item_selected;
    logic                       selection_valid;
    logic                       sel_reject;
    // price RAM
    logic                       price_rd_en;
    logic [ITEM_ADDR_WIDTH-1:0] price_rd_addr;
    logic [CREDIT_WIDTH-1:0]    price_rdata;
    logic                       item_avail;
    // coin acceptor and user
    logic                       coin_valid;
    logic [COIN_WIDTH-1:0]      coin_value;
    logic                       coin_reject;
    logic                       cancel;
    // dispenser handshake
    logic                       dispense_valid;
    logic [ITEM_ADDR_WIDTH-1:0] dispense_item;
    logic                       dispense_ready;
    // change unit handshake
    logic                       change_valid;
    logic [CREDIT_WIDTH-1:0]    change_amount;
    logic                       change_ready;
    // status
    logic                       busy;
    logic                       txn_error;

    modport master (
        input  item_selected, selection_valid, price_rdata, item_avail,
               coin_valid, coin_value, cancel, dispense_ready, change_ready,
        output sel_reject, price_rd_en, price_rd_addr, coin_reject,
               dispense_valid, dispense_item, change_valid, change_amount,
               busy, txn_error
    );

    modport slave (
        output item_selected, selection_valid, price_rdata, item_avail,
               coin_valid, coin_value, cancel, dispense_ready, change_ready,
        input  sel_reject, price_rd_en, price_rd_addr, coin_reject,
               dispense_valid, dispense_item, change_valid, change_amount,
               busy, txn_error
    );

endinterface

// File: rtl/vend_credit_acc.sv
// Purpose: coin credit accumulator with overflow rejection and an idle timeout counter.
// Latency: credit updates on the edge after the coin; o_credit_nxt shows the post-coin value same cycle.
// Backpressure: none; a coin that would overflow is dropped and flagged one cycle later.
// Ports: i_clear zeroes credit/counter; i_enable marks the collect window; o_timeout fires
//        combinationally in the last allowed idle cycle.
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int COIN_WIDTH     = VEND_COIN_WIDTH,
    parameter int CREDIT_WIDTH   = VEND_CREDIT_WIDTH,
    parameter int TIMEOUT_CYCLES = VEND_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_clear,
    input  logic                    i_enable,
    input  logic                    i_coin_valid,
    input  logic [COIN_WIDTH-1:0]   i_coin_value,
    output logic [CREDIT_WIDTH-1:0] o_credit,
    output logic [CREDIT_WIDTH-1:0] o_credit_nxt,
    output logic                    o_overflow_reject,
    output logic                    o_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CREDIT_WIDTH-1:0] r_credit;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_rej;
    logic [CREDIT_WIDTH:0]   w_sum;
    logic                    w_coin_ok;

    // one extra bit catches a sum that no longer fits in the credit register
    assign w_sum     = {1'b0, r_credit} + (CREDIT_WIDTH+1)'(i_coin_value);
    assign w_coin_ok = i_enable && i_coin_valid && !w_sum[CREDIT_WIDTH];

    assign o_credit          = r_credit;
    assign o_credit_nxt      = w_coin_ok ? w_sum[CREDIT_WIDTH-1:0] : r_credit;
    assign o_overflow_reject = r_ovf_rej;
    assign o_timeout         = i_enable && !w_coin_ok && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_credit  <= '0;
            r_cnt     <= '0;
            r_ovf_rej <= 1'b0;
        end else begin
            r_ovf_rej <= i_enable && i_coin_valid && w_sum[CREDIT_WIDTH];
            if (i_clear) begin
                r_credit <= '0;
                r_cnt    <= '0;
            end else if (i_enable) begin
                r_credit <= o_credit_nxt;
                if (w_coin_ok) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_LAST) begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Purpose: one-at-a-time vending transaction: price lookup, coin collection, dispense, change/refund.
// Latency: selection to first COLLECT cycle is 3 cycles; reject/error pulses come 1 cycle after the cause.
// Backpressure: dispense/change requests hold valid and payload until ready; selections while busy are rejected.
// Ports: clk/rstn plain; everything else through vend_txn_ctrl_if.master (selection, price RAM,
//        coins, cancel, dispense and change handshakes, busy/txn_error status).
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int ITEM_ADDR_WIDTH = VEND_ITEM_ADDR_WIDTH,
    parameter int COIN_WIDTH      = VEND_COIN_WIDTH,
    parameter int CREDIT_WIDTH    = VEND_CREDIT_WIDTH,
    parameter int TIMEOUT_CYCLES  = VEND_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rstn,
    vend_txn_ctrl_if.master bus
);
    vend_state_t                r_state;
    vend_state_t                w_state_nxt;
    logic [ITEM_ADDR_WIDTH-1:0] r_item;
    logic [CREDIT_WIDTH-1:0]    r_price;
    logic [CREDIT_WIDTH-1:0]    r_change;
    logic                       r_sel_rej;
    logic                       r_coin_rej;
    logic                       r_txn_err;

    logic                       w_acc_clear;
    logic                       w_acc_en;
    logic [CREDIT_WIDTH-1:0]    w_credit;
    logic [CREDIT_WIDTH-1:0]    w_credit_nxt;
    logic                       w_ovf_rej;
    logic                       w_timeout;
    logic                       w_price_bad;
    logic                       w_paid;
    logic                       w_refund_req;

    assign w_price_bad  = !bus.item_avail || (bus.price_rdata == '0);
    // exit decisions use the credit including a coin arriving this cycle
    assign w_paid       = (w_credit_nxt >= r_price);
    assign w_refund_req = bus.cancel || w_timeout;
    assign w_acc_en     = (r_state == ST_COLLECT);
    assign w_acc_clear  = (r_state == ST_PRICE_CHK)
                       || ((r_state == ST_DISPENSE) && bus.dispense_ready)
                       || ((r_state == ST_CHANGE) && bus.change_ready);

    vend_credit_acc #(
        .COIN_WIDTH     (COIN_WIDTH),
        .CREDIT_WIDTH   (CREDIT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_credit_acc (
        .clk               (clk),
        .rstn              (rstn),
        .i_clear           (w_acc_clear),
        .i_enable          (w_acc_en),
        .i_coin_valid      (bus.coin_valid),
        .i_coin_value      (bus.coin_value),
        .o_credit          (w_credit),
        .o_credit_nxt      (w_credit_nxt),
        .o_overflow_reject (w_ovf_rej),
        .o_timeout         (w_timeout)
    );

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.selection_valid) w_state_nxt = ST_PRICE_RD;
            end
            ST_PRICE_RD: begin
                w_state_nxt = ST_PRICE_CHK;
            end
            ST_PRICE_CHK: begin
                w_state_nxt = w_price_bad ? ST_IDLE : ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_paid) begin
                    w_state_nxt = ST_DISPENSE;
                end else if (w_refund_req) begin
                    // nothing to return when no coin was ever credited
                    w_state_nxt = (w_credit_nxt != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_DISPENSE: begin
                if (bus.dispense_ready) begin
                    w_state_nxt = (w_credit != r_price) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (bus.change_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // transaction datapath and one-cycle status pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_item     <= '0;
            r_price    <= '0;
            r_change   <= '0;
            r_sel_rej  <= 1'b0;
            r_coin_rej <= 1'b0;
            r_txn_err  <= 1'b0;
        end else begin
            r_sel_rej  <= bus.selection_valid && (r_state != ST_IDLE);
            r_coin_rej <= bus.coin_valid && (r_state != ST_COLLECT);
            r_txn_err  <= (r_state == ST_PRICE_CHK) && w_price_bad;

            if ((r_state == ST_IDLE) && bus.selection_valid) begin
                r_item <= bus.item_selected;
            end
            if (r_state == ST_PRICE_CHK) begin
                r_price <= bus.price_rdata;
            end
            if ((r_state == ST_COLLECT) && !w_paid && w_refund_req) begin
                r_change <= w_credit_nxt;
            end else if ((r_state == ST_DISPENSE) && bus.dispense_ready) begin
                // only reached with credit >= price, so no underflow
                r_change <= w_credit - r_price;
            end
        end
    end

    // outputs decoded from state and registered pulses
    always_comb begin
        bus.price_rd_en    = 1'b0;
        bus.price_rd_addr  = '0;
        bus.dispense_valid = 1'b0;
        bus.dispense_item  = '0;
        bus.change_valid   = 1'b0;
        bus.change_amount  = '0;
        bus.busy           = (r_state != ST_IDLE);
        bus.sel_reject     = r_sel_rej;
        bus.coin_reject    = r_coin_rej || w_ovf_rej;
        bus.txn_error      = r_txn_err;
        case (r_state)
            ST_PRICE_RD: begin
                bus.price_rd_en   = 1'b1;
                bus.price_rd_addr = r_item;
            end
            ST_DISPENSE: begin
                bus.dispense_valid = 1'b1;
                bus.dispense_item  = r_item;
            end
            ST_CHANGE: begin
                bus.change_valid  = 1'b1;
                bus.change_amount = r_change;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
module tb_vend_txn_ctrl;
    import vend_pkg::*;

    localparam int IAW   = 10;
    localparam int COINW = 8;
    localparam int CW    = 12;
    localparam int CW8   = 8;
    localparam int TO    = 1000;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [IAW-1:0]   item_selected;
    logic             selection_valid;
    logic             coin_valid;
    logic [COINW-1:0] coin_value;
    logic             cancel;
    logic             dispense_ready;
    logic             change_ready;
    logic [CW-1:0]    price_rdata = '0;
    logic             item_avail  = 1'b0;
    logic [CW-1:0]    ram_price;
    logic             ram_avail;

    int checks = 0;
    int errors = 0;

    vend_txn_ctrl_if #(.ITEM_ADDR_WIDTH(IAW), .COIN_WIDTH(COINW), .CREDIT_WIDTH(CW))  bus ();
    vend_txn_ctrl_if #(.ITEM_ADDR_WIDTH(IAW), .COIN_WIDTH(COINW), .CREDIT_WIDTH(CW8)) bus8 ();

    assign bus.item_selected    = item_selected;
    assign bus.selection_valid  = selection_valid;
    assign bus.coin_valid       = coin_valid;
    assign bus.coin_value       = coin_value;
    assign bus.cancel           = cancel;
    assign bus.dispense_ready   = dispense_ready;
    assign bus.change_ready     = change_ready;
    assign bus.price_rdata      = price_rdata;
    assign bus.item_avail       = item_avail;
    assign bus8.item_selected   = item_selected;
    assign bus8.selection_valid = selection_valid;
    assign bus8.coin_valid      = coin_valid;
    assign bus8.coin_value      = coin_value;
    assign bus8.cancel          = cancel;
    assign bus8.dispense_ready  = dispense_ready;
    assign bus8.change_ready    = change_ready;
    assign bus8.price_rdata     = price_rdata[CW8-1:0];
    assign bus8.item_avail      = item_avail;

    vend_txn_ctrl #(.ITEM_ADDR_WIDTH(IAW), .COIN_WIDTH(COINW), .CREDIT_WIDTH(CW), .TIMEOUT_CYCLES(TO))
        dut (.clk(clk), .rstn(rstn), .bus(bus));
    vend_txn_ctrl #(.ITEM_ADDR_WIDTH(IAW), .COIN_WIDTH(COINW), .CREDIT_WIDTH(CW8), .TIMEOUT_CYCLES(TO))
        dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

    // every output of each DUT packed together for all-zero checks
    wire [38:0] outs = {bus.price_rd_en, bus.price_rd_addr, bus.coin_reject, bus.sel_reject,
                        bus.dispense_valid, bus.dispense_item, bus.change_valid, bus.change_amount,
                        bus.busy, bus.txn_error};
    wire [34:0] outs8 = {bus8.price_rd_en, bus8.price_rd_addr, bus8.coin_reject, bus8.sel_reject,
                         bus8.dispense_valid, bus8.dispense_item, bus8.change_valid, bus8.change_amount,
                         bus8.busy, bus8.txn_error};

    // price RAM: data and stock flag are valid exactly one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.price_rd_en) begin
            price_rdata <= ram_price;
            item_avail  <= ram_avail;
        end else begin
            price_rdata <= '0;
            item_avail  <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic select_item(input logic [IAW-1:0] it, input int price, input logic avail);
        ram_price       = CW'(price);
        ram_avail       = avail;
        item_selected   = it;
        selection_valid = 1'b1;
        @(negedge clk);
        selection_valid = 1'b0;
        checks++; if (bus.price_rd_en !== 1'b1 || bus.price_rd_addr !== it) begin errors++;
            $display("FAIL price_read: en=%0b addr=%0h expected en=1 addr=%0h", bus.price_rd_en, bus.price_rd_addr, it); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic insert_coin(input int v);
        coin_valid = 1'b1;
        coin_value = COINW'(v);
        @(negedge clk);
        coin_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %0h expected 0", outs); end
        checks++; if (outs8 !== '0) begin errors++; $display("FAIL reset_outs8: got %0h expected 0", outs8); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%0b expected 0", bus.busy); end
    endtask

    task automatic test_exact_pay();
        bit seen_change;
        select_item(10'h123, 50, 1'b1);
        checks++; if (bus.busy !== 1'b1 || bus.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL collect_entry: busy=%0b dv=%0b expected busy=1 dv=0", bus.busy, bus.dispense_valid); end
        insert_coin(25);
        checks++; if (bus.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL partial_credit: dv=%0b expected 0", bus.dispense_valid); end
        insert_coin(25);
        checks++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 10'h123) begin errors++;
            $display("FAIL exact_dispense: dv=%0b item=%0h expected 1/123", bus.dispense_valid, bus.dispense_item); end
        @(negedge clk);
        checks++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 10'h123) begin errors++;
            $display("FAIL dispense_hold: dv=%0b item=%0h expected 1/123", bus.dispense_valid, bus.dispense_item); end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        seen_change = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL exact_idle: busy=%0b dv=%0b expected 0/0", bus.busy, bus.dispense_valid); end
        for (int i = 0; i < 3; i++) begin
            if (bus.change_valid === 1'b1) seen_change = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_change !== 1'b0) begin errors++; $display("FAIL exact_no_change: got change_valid expected none"); end
    endtask

    task automatic test_overpay();
        select_item(10'h045, 30, 1'b1);
        insert_coin(25);
        insert_coin(10);
        checks++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 10'h045) begin errors++;
            $display("FAIL overpay_dispense: dv=%0b item=%0h expected 1/45", bus.dispense_valid, bus.dispense_item); end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 12'd5) begin errors++;
            $display("FAIL overpay_change: cv=%0b amt=%0d expected 1/5", bus.change_valid, bus.change_amount); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 12'd5) begin errors++;
                $display("FAIL change_hold: cv=%0b amt=%0d expected 1/5", bus.change_valid, bus.change_amount); end
        end
        change_ready = 1'b1;
        @(negedge clk);
        change_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.change_valid !== 1'b0) begin errors++;
            $display("FAIL overpay_idle: busy=%0b cv=%0b expected 0/0", bus.busy, bus.change_valid); end
    endtask

    task automatic test_cancel();
        select_item(10'h0A1, 100, 1'b1);
        insert_coin(20);
        coin_valid = 1'b1;
        coin_value = 8'd10;
        cancel     = 1'b1;
        @(negedge clk);
        coin_valid = 1'b0;
        cancel     = 1'b0;
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 12'd30 || bus.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL cancel_refund: cv=%0b amt=%0d dv=%0b expected 1/30/0", bus.change_valid, bus.change_amount, bus.dispense_valid); end
        change_ready = 1'b1;
        @(negedge clk);
        change_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_idle: busy=%0b expected 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int n;
        select_item(10'h0A2, 100, 1'b1);
        insert_coin(20);
        n = 0;
        while (bus.change_valid !== 1'b1 && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== TO) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected %0d", n, TO); end
        checks++; if (bus.change_amount !== 12'd20) begin errors++;
            $display("FAIL timeout_amount: got %0d expected 20", bus.change_amount); end
        change_ready = 1'b1;
        @(negedge clk);
        change_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%0b expected 0", bus.busy); end
    endtask

    task automatic test_unavail(input logic avail, input int price);
        select_item(10'h077, price, avail);
        checks++; if (bus.txn_error !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL unavail_error: err=%0b busy=%0b expected 1/0", bus.txn_error, bus.busy); end
        checks++; if (bus.dispense_valid !== 1'b0 || bus.change_valid !== 1'b0) begin errors++;
            $display("FAIL unavail_no_output: dv=%0b cv=%0b expected 0/0", bus.dispense_valid, bus.change_valid); end
        @(negedge clk);
        checks++; if (bus.txn_error !== 1'b0) begin errors++; $display("FAIL unavail_pulse: err=%0b expected 0", bus.txn_error); end
    endtask

    task automatic test_rejects();
        insert_coin(5);
        checks++; if (bus.coin_reject !== 1'b1) begin errors++; $display("FAIL idle_coin_reject: got %0b expected 1", bus.coin_reject); end
        @(negedge clk);
        checks++; if (bus.coin_reject !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL idle_coin_pulse: rej=%0b busy=%0b expected 0/0", bus.coin_reject, bus.busy); end
        select_item(10'h0F0, 40, 1'b1);
        item_selected   = 10'h2AA;
        selection_valid = 1'b1;
        @(negedge clk);
        selection_valid = 1'b0;
        checks++; if (bus.sel_reject !== 1'b1 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL busy_sel_reject: rej=%0b busy=%0b expected 1/1", bus.sel_reject, bus.busy); end
        insert_coin(40);
        checks++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 10'h0F0) begin errors++;
            $display("FAIL latched_item: dv=%0b item=%0h expected 1/f0", bus.dispense_valid, bus.dispense_item); end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.change_valid !== 1'b0) begin errors++;
            $display("FAIL reject_idle: busy=%0b cv=%0b expected 0/0 (credit started at 0)", bus.busy, bus.change_valid); end
    endtask

    task automatic test_overflow();
        select_item(10'h0AB, 255, 1'b1);
        insert_coin(200);
        insert_coin(50);
        insert_coin(10);
        checks++; if (bus8.coin_reject !== 1'b1 || bus8.busy !== 1'b1 || bus8.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL ovf_reject8: rej=%0b busy=%0b dv=%0b expected 1/1/0", bus8.coin_reject, bus8.busy, bus8.dispense_valid); end
        checks++; if (bus.dispense_valid !== 1'b1 || bus.coin_reject !== 1'b0) begin errors++;
            $display("FAIL wide_accept: dv=%0b rej=%0b expected 1/0", bus.dispense_valid, bus.coin_reject); end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (bus8.change_valid !== 1'b1 || bus8.change_amount !== 8'd250) begin errors++;
            $display("FAIL ovf_refund8: cv=%0b amt=%0d expected 1/250", bus8.change_valid, bus8.change_amount); end
        checks++; if (bus.dispense_valid !== 1'b1 || bus.change_valid !== 1'b0) begin errors++;
            $display("FAIL cancel_in_dispense: dv=%0b cv=%0b expected 1/0", bus.dispense_valid, bus.change_valid); end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 12'd5) begin errors++;
            $display("FAIL wide_change: cv=%0b amt=%0d expected 1/5", bus.change_valid, bus.change_amount); end
        change_ready = 1'b1;
        @(negedge clk);
        change_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus8.busy !== 1'b0) begin errors++;
            $display("FAIL ovf_idle: busy=%0b busy8=%0b expected 0/0", bus.busy, bus8.busy); end
    endtask

    task automatic test_reset_mid_dispense();
        select_item(10'h155, 20, 1'b1);
        insert_coin(20);
        checks++; if (bus.dispense_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_dispense: dv=%0b expected 1", bus.dispense_valid); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (outs !== '0 || outs8 !== '0) begin errors++;
            $display("FAIL async_reset_outs: got %0h/%0h expected 0/0", outs, outs8); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.dispense_valid !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle: busy=%0b dv=%0b expected 0/0", bus.busy, bus.dispense_valid); end
        select_item(10'h0C3, 15, 1'b1);
        insert_coin(15);
        checks++; if (bus.dispense_valid !== 1'b1 || bus.dispense_item !== 10'h0C3) begin errors++;
            $display("FAIL post_reset_txn: dv=%0b item=%0h expected 1/c3", bus.dispense_valid, bus.dispense_item); end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.change_valid !== 1'b0) begin errors++;
            $display("FAIL post_reset_idle2: busy=%0b cv=%0b expected 0/0", bus.busy, bus.change_valid); end
    endtask

    initial begin
        item_selected   = '0;
        selection_valid = 1'b0;
        coin_valid      = 1'b0;
        coin_value      = '0;
        cancel          = 1'b0;
        dispense_ready  = 1'b0;
        change_ready    = 1'b0;
        ram_price       = '0;
        ram_avail       = 1'b0;

        test_reset();
        test_exact_pay();
        test_overpay();
        test_cancel();
        test_timeout();
        test_unavail(1'b0, 50);
        test_unavail(1'b1, 0);
        test_rejects();
        test_overflow();
        test_reset_mid_dispense();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
